// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one add/multiply unit among NREQ requesters.
// Each winner takes three cycles: grant, compute, result strobe tagged with its index.
module alu_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   in_a,
  input  logic [NREQ*WIDTH-1:0]   in_b,
  input  logic [NREQ-1:0]         mode,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic                    out_valid,
  output logic [2*WIDTH-1:0]      out,
  output logic [IDW-1:0]          out_id,
  output logic [15:0]             op_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_OUT     = 2'd2
  } state_t;

  state_t             state;
  logic [IDW-1:0]     ptr;

  logic [WIDTH-1:0]   lat_a;
  logic [WIDTH-1:0]   lat_b;
  logic               lat_mode;
  logic [IDW-1:0]     lat_id;

  logic               win_found;
  logic [IDW-1:0]     win_idx;
  logic [WIDTH-1:0]   win_a;
  logic [WIDTH-1:0]   win_b;
  logic               win_mode;
  logic [IDW-1:0]     ptr_next;
  int                 cand;

  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] result;

  // Search starts at ptr and wraps, so the most recent winner is visited last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    win_found = 1'b0;
    win_idx   = '0;
    win_a     = '0;
    win_b     = '0;
    win_mode  = 1'b0;
    cand      = 0;
    for (int off = 0; off < NREQ; off++) begin
      cand = (int'(ptr) + off) % NREQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = IDW'(cand);
        win_a     = in_a[cand*WIDTH +: WIDTH];
        win_b     = in_b[cand*WIDTH +: WIDTH];
        win_mode  = mode[cand];
      end
    end
  end

  always_comb begin
    ptr_next = '0;
    if (win_idx != IDW'(NREQ - 1)) begin
      ptr_next = win_idx + IDW'(1);
    end
  end

  // Zero-extended operands make a 2*WIDTH result wide enough for both a+b and a*b.
  always_comb begin
    ext_a  = {{WIDTH{1'b0}}, lat_a};
    ext_b  = {{WIDTH{1'b0}}, lat_b};
    result = lat_mode ? (ext_a * ext_b) : (ext_a + ext_b);
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      lat_a     <= '0;
      lat_b     <= '0;
      lat_mode  <= 1'b0;
      lat_id    <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      out_id    <= '0;
      op_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          gnt       <= '0;
          out_valid <= 1'b0;
          out       <= '0;
          out_id    <= '0;
          busy      <= 1'b0;
          if (win_found) begin
            lat_a    <= win_a;
            lat_b    <= win_b;
            lat_mode <= win_mode;
            lat_id   <= win_idx;
            gnt      <= NREQ'(1) << win_idx;
            ptr      <= ptr_next;
            busy     <= 1'b1;
            state    <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          gnt       <= '0;
          out       <= result;
          out_valid <= 1'b1;
          out_id    <= lat_id;
          op_cnt    <= op_cnt + 16'd1;
          busy      <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          gnt       <= '0;
          out_valid <= 1'b0;
          out       <= '0;
          out_id    <= '0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          gnt       <= '0;
          out_valid <= 1'b0;
          out       <= '0;
          out_id    <= '0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
